// File: rtl/sp128_arbiter.sv
// rtl/sp128_arbiter.sv - round-robin two-port arbiter/sequencer for a 128x8 single-port RAM
// Define SP128_INIT_CLEAR_EN to zero the RAM with a 128-cycle sweep after reset.
module sp128_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              init_busy,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_reset,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

`ifdef SP128_INIT_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic              ptr_q, ptr_d;  // 0: A wins a tie, 1: B wins a tie
  logic              a_pend_q, a_pend_d, b_pend_q, b_pend_d;
  logic              s1_vld_q, s1_vld_d, s1_port_q, s1_port_d, s1_we_q, s1_we_d;
  logic              s2_vld_q, s2_port_q, s2_we_q;
  logic              ram_ce_q, ram_ce_d, ram_wre_q, ram_wre_d;
  logic [ADDR_W-1:0] ram_ad_q, ram_ad_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              a_ack_q, b_ack_q;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              busy_q, busy_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic              a_elig, b_elig, a_done, b_done, grant_a, grant_b;

  assign a_elig = a_req & ~a_pend_q;
  assign b_elig = b_req & ~b_pend_q;
  assign a_done = s2_vld_q & ~s2_port_q;
  assign b_done = s2_vld_q & s2_port_q;

  always_comb begin
    ptr_d     = ptr_q;
    ram_ce_d  = 1'b0;
    ram_wre_d = 1'b0;
    ram_ad_d  = ram_ad_q;
    ram_din_d = ram_din_q;
    s1_vld_d  = 1'b0;
    s1_port_d = s1_port_q;
    s1_we_d   = s1_we_q;
    busy_d    = busy_q;
    clr_cnt_d = clr_cnt_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    if (busy_q) begin
      // Sweep counter runs one past the last address; that extra cycle releases busy.
      if (!clr_cnt_q[ADDR_W]) begin
        ram_ce_d  = 1'b1;
        ram_wre_d = 1'b1;
        ram_ad_d  = clr_cnt_q[ADDR_W-1:0];
        ram_din_d = '0;
        clr_cnt_d = clr_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
      end else begin
        busy_d = 1'b0;
      end
    end else begin
      if (a_elig && b_elig) begin
        grant_a = ~ptr_q;
        grant_b = ptr_q;
        ptr_d   = ~ptr_q;
      end else begin
        grant_a = a_elig;
        grant_b = b_elig;
      end
      if (grant_a || grant_b) begin
        ram_ce_d  = 1'b1;
        ram_wre_d = grant_b ? b_we : a_we;
        ram_ad_d  = grant_b ? b_addr : a_addr;
        ram_din_d = grant_b ? b_wdata : a_wdata;
        s1_vld_d  = 1'b1;
        s1_port_d = grant_b;
        s1_we_d   = grant_b ? b_we : a_we;
      end
    end
    a_pend_d  = (a_pend_q & ~a_done) | grant_a;
    b_pend_d  = (b_pend_q & ~b_done) | grant_b;
    a_rdata_d = (a_done && !s2_we_q) ? ram_dout : a_rdata_q;
    b_rdata_d = (b_done && !s2_we_q) ? ram_dout : b_rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= 1'b0;
      a_pend_q  <= 1'b0;
      b_pend_q  <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_port_q <= 1'b0;
      s1_we_q   <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_port_q <= 1'b0;
      s2_we_q   <= 1'b0;
      ram_ce_q  <= 1'b0;
      ram_wre_q <= 1'b0;
      ram_ad_q  <= '0;
      ram_din_q <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      busy_q    <= BUSY_RST;
      clr_cnt_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      a_pend_q  <= a_pend_d;
      b_pend_q  <= b_pend_d;
      s1_vld_q  <= s1_vld_d;
      s1_port_q <= s1_port_d;
      s1_we_q   <= s1_we_d;
      s2_vld_q  <= s1_vld_q;
      s2_port_q <= s1_port_q;
      s2_we_q   <= s1_we_q;
      ram_ce_q  <= ram_ce_d;
      ram_wre_q <= ram_wre_d;
      ram_ad_q  <= ram_ad_d;
      ram_din_q <= ram_din_d;
      a_ack_q   <= a_done;
      b_ack_q   <= b_done;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      busy_q    <= busy_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign init_busy = busy_q;
  assign ram_ce    = ram_ce_q;
  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;
  assign ram_wre   = ram_wre_q;
  assign ram_ad    = ram_ad_q;
  assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_sp128_arbiter.sv
// tb/tb_sp128_arbiter.sv - randomized and directed bench for sp128_arbiter against a behavioural model
// Follows SP128_INIT_CLEAR_EN the same way as the design.
module tb_sp128_arbiter;
`ifdef SP128_INIT_CLEAR_EN
  localparam bit INIT = 1'b1;
`else
  localparam bit INIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [6:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic a_ack, b_ack, init_busy, ram_ce, ram_oce, ram_reset, ram_wre;
  logic [7:0] a_rdata, b_rdata, ram_din;
  logic [6:0] ram_ad;
  logic [7:0] ram_dout = '0;
  logic [7:0] ram_mem [0:127];

  int checks = 0, errors = 0, ncyc = 0;
  int a_ack_cnt = 0, b_ack_cnt = 0;
  bit log_en = 0;
  int ack_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) ncyc++;

  sp128_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .init_busy(init_busy), .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_reset(ram_reset),
    .ram_wre(ram_wre), .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM model: read data appears after the edge that samples the address
  always @(posedge clk)
    if (ram_ce) begin
      if (ram_wre) ram_mem[ram_ad] <= ram_din;
      else ram_dout <= ram_mem[ram_ad];
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req_v, $time);
    end
  endtask

  // Behavioural model: a port is busy for the two edges after its grant; accesses are serialized
  typedef struct { int port; bit we; int addr; int data; int edge_n; } txn_t;
  txn_t inflight[$];
  txn_t t;
  logic [7:0] mmem [0:127];
  int cyc = 0, ptr = 0, last_a = -100, last_b = -100, g;
  bit ea, eb;
  bit e_ce = 0, e_wre = 0, e_ack_a = 0, e_ack_b = 0, e_busy = INIT;
  int e_ad = 0, e_din = 0;
  logic [7:0] e_rd_a = '0, e_rd_b = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc = 0; ptr = 0; last_a = -100; last_b = -100; inflight.delete();
      e_ce = 0; e_wre = 0; e_ad = 0; e_din = 0; e_ack_a = 0; e_ack_b = 0;
      e_rd_a = '0; e_rd_b = '0; e_busy = INIT;
      if (INIT) for (int i = 0; i < 128; i++) mmem[i] = 8'h00;
    end else begin
      cyc++;
      e_ack_a = 0; e_ack_b = 0; e_ce = 0; e_wre = 0;
      if (inflight.size() > 0 && inflight[0].edge_n == cyc - 2) begin
        t = inflight.pop_front();
        if (t.port == 0) begin e_ack_a = 1; if (!t.we) e_rd_a = t.data[7:0]; end
        else begin e_ack_b = 1; if (!t.we) e_rd_b = t.data[7:0]; end
      end
      if (INIT && cyc <= 128) begin
        e_ce = 1; e_wre = 1; e_ad = cyc - 1; e_din = 0;
      end else if (!INIT || cyc >= 130) begin
        ea = a_req && (cyc - last_a >= 3);
        eb = b_req && (cyc - last_b >= 3);
        g = -1;
        if (ea && eb) begin g = ptr; ptr = 1 - ptr; end
        else if (ea) g = 0;
        else if (eb) g = 1;
        if (g >= 0) begin
          t.port = g;
          t.we = (g == 0) ? a_we : b_we;
          t.addr = (g == 0) ? a_addr : b_addr;
          t.data = (g == 0) ? a_wdata : b_wdata;
          t.edge_n = cyc;
          e_ce = 1; e_wre = t.we; e_ad = t.addr; e_din = t.data;
          if (t.we) mmem[t.addr] = t.data[7:0];
          else t.data = mmem[t.addr];
          inflight.push_back(t);
          if (g == 0) last_a = cyc; else last_b = cyc;
        end
      end
      e_busy = INIT && (cyc < 129);
    end
  end

  always @(negedge clk) begin
    chk("ram_ce", ram_ce, e_ce);
    chk("ram_wre", ram_wre, e_wre);
    if (e_ce || !reset_n) begin
      chk("ram_ad", ram_ad, e_ad);
      chk("ram_din", ram_din, e_din);
    end
    chk("a_ack", a_ack, e_ack_a);
    chk("b_ack", b_ack, e_ack_b);
    chk("a_rdata", a_rdata, e_rd_a);
    chk("b_rdata", b_rdata, e_rd_b);
    chk("init_busy", init_busy, e_busy);
    chk("ram_oce", ram_oce, 1);
    chk("ram_reset", ram_reset, 0);
    if (a_ack) a_ack_cnt++;
    if (b_ack) b_ack_cnt++;
    if (log_en && a_ack) ack_log.push_back(0);
    if (log_en && b_ack) ack_log.push_back(1);
  end

  task automatic set_port(input int p, input bit req, input bit we, input int ad, input int wd);
    if (p == 0) begin a_we = we; a_addr = ad[6:0]; a_wdata = wd[7:0]; a_req = req; end
    else begin b_we = we; b_addr = ad[6:0]; b_wdata = wd[7:0]; b_req = req; end
  endtask

  // Call at a negedge; returns the ncyc of the ack cycle and the read data
  task automatic do_req(input int p, input bit we, input int ad, input int wd, input int lim,
                        output int t_ack, output logic [7:0] rd);
    bit got = 0;
    t_ack = -1; rd = '0;
    set_port(p, 1, we, ad, wd);
    for (int n = 0; n < lim && !got; n++) begin
      @(negedge clk);
      if ((p == 0) ? a_ack : b_ack) begin
        got = 1; t_ack = ncyc; rd = (p == 0) ? a_rdata : b_rdata;
      end
    end
    if (p == 0) a_req = 0; else b_req = 0;
    chk("ack_seen", got, 1);
  endtask

  task automatic stream(input int p, input int n, output int cnt);
    cnt = 0;
    set_port(p, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255));
    for (int k = 0; k < 300 && cnt < n; k++) begin
      @(negedge clk);
      if ((p == 0) ? a_ack : b_ack) begin
        cnt++;
        if (cnt < n) set_port(p, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255));
      end
    end
    if (p == 0) a_req = 0; else b_req = 0;
  endtask

  task automatic rand_port(input int p, input int n);
    int ta;
    logic [7:0] rd;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_req(p, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255), 40, ta, rd);
    end
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, ta, tb, busy_n, cnt_a, cnt_b, alt_bad, nb0;
    logic [7:0] rd, rdb, pre0;
    bit got;
    for (int i = 0; i < 128; i++) begin
      ram_mem[i] = INIT ? 8'hFF : 8'($urandom_range(0, 255));
      mmem[i] = ram_mem[i];
    end
    pre0 = ram_mem[0];
    repeat (3) @(negedge clk);
    chk("rst_ram_ce", ram_ce, 0);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_busy", init_busy, INIT);

    // First request right at reset release: A reads address 0
    #2 reset_n = 1;
    t0 = ncyc;
    busy_n = 0;
    fork
      do_req(0, 0, 0, 0, 300, ta, rd);
      for (int n = 0; n < 300 && init_busy; n++) begin
        @(negedge clk);
        if (init_busy) busy_n++;
      end
    join
    chk("busy_cycles", busy_n, INIT ? 128 : 0);
    chk("first_lat", ta - t0, INIT ? 132 : 3);
    chk("first_rdata", rd, INIT ? 8'h00 : pre0);

    // Single write then read on A, B silent
    nb0 = b_ack_cnt;
    @(negedge clk);
    do_req(0, 1, 8'h10, 8'h5A, 40, ta, rd);
    t0 = ncyc;
    do_req(0, 0, 8'h10, 0, 40, ta, rd);
    chk("single_lat", ta - t0, 3);
    chk("single_rdata", rd, 8'h5A);
    chk("single_no_b_ack", b_ack_cnt - nb0, 0);

    // Contention twice: pointer starts at A, then favours B
    @(negedge clk);
    fork
      do_req(0, 1, 8'h20, 8'h11, 40, ta, rd);
      do_req(1, 1, 8'h21, 8'h22, 40, tb, rdb);
    join
    chk("cont1_order", tb - ta, 1);
    @(negedge clk);
    fork
      do_req(0, 0, 8'h21, 0, 40, ta, rd);
      do_req(1, 0, 8'h20, 0, 40, tb, rdb);
    join
    chk("cont2_order", ta - tb, 1);
    chk("cont2_a_rdata", rd, 8'h22);
    chk("cont2_b_rdata", rdb, 8'h11);

    // Cross-port write then read of 0x7F
    @(negedge clk);
    fork
      do_req(0, 1, 8'h7F, 8'hC3, 40, ta, rd);
      begin
        @(negedge clk);
        do_req(1, 0, 8'h7F, 0, 40, tb, rdb);
      end
    join
    chk("cross_rdata", rdb, 8'hC3);

    // Streaming: both ports hold req for 20 transactions each
    @(negedge clk);
    ack_log.delete();
    log_en = 1;
    fork
      stream(0, 20, cnt_a);
      stream(1, 20, cnt_b);
    join
    repeat (3) @(negedge clk);
    log_en = 0;
    chk("stream_a_cnt", cnt_a, 20);
    chk("stream_b_cnt", cnt_b, 20);
    chk("stream_total", ack_log.size(), 40);
    alt_bad = 0;
    for (int i = 1; i < ack_log.size(); i++) if (ack_log[i] == ack_log[i-1]) alt_bad++;
    chk("stream_alternate", alt_bad, 0);

    // Randomized traffic on both ports, checked cycle by cycle against the model
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (4) @(negedge clk);

    // Reset the cycle after a B read is granted
    b_we = 0; b_addr = 7'h10; b_req = 1;
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (ram_ce && !ram_wre && ram_ad == 7'h10) got = 1;
    end
    chk("rst_grant_seen", got, 1);
    nb0 = b_ack_cnt;
    #2 reset_n = 0;
    #1;
    chk("async_ram_ce", ram_ce, 0);
    chk("async_ram_wre", ram_wre, 0);
    chk("async_ram_ad", ram_ad, 0);
    chk("async_ram_din", ram_din, 0);
    chk("async_b_ack", b_ack, 0);
    chk("async_a_rdata", a_rdata, 0);
    chk("async_b_rdata", b_rdata, 0);
    chk("async_busy", init_busy, INIT);
    b_req = 0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1;
    repeat (6) @(negedge clk);
    chk("rst_no_b_ack", b_ack_cnt - nb0, 0);
    for (int n = 0; n < 300 && init_busy; n++) @(negedge clk);
    chk("busy_done", init_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
